// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: d = a - b - b_in, one 4-bit nibble per clock, LSB first.
// Define SUB_FLAGS_EN to add registered zero/neg/ovf result flags.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
`ifdef SUB_FLAGS_EN
    output logic             b_out,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`else
    output logic             b_out
`endif
);

    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_nxt;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic             b_out_q;
    logic             out_valid_q;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       sum;
    logic             last;
    logic             accept;
    logic             release_res;

    assign accept      = (state_q == IDLE) && in_valid;
    assign release_res = out_valid_q && out_ready;
    assign last        = (idx_q == IW'(NIB - 1));

    // Subtraction as a + ~b + ~borrow, one nibble per cycle
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i*4 +: 4];
                b_nib = b_q[i*4 +: 4];
            end
        end
        sum   = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, carry_q};
        d_nxt = d_q;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IW'(i)) begin
                d_nxt[i*4 +: 4] = sum[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid)    state_d = RUN;
            RUN:  if (last)        state_d = DONE;
            DONE: if (release_res) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            b_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= ~b_in;
                idx_q   <= '0;
            end
            if (state_q == RUN) begin
                d_q     <= d_nxt;
                carry_q <= sum[4];
                idx_q   <= idx_q + 1'b1;
                if (last) begin
                    b_out_q <= ~sum[4];
                end
            end
            // Result is published one cycle after the last nibble settles
            if (state_q == DONE) begin
                out_valid_q <= !release_res;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign b_out     = b_out_q;

`ifdef SUB_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == RUN && last) begin
            zero_q <= (d_nxt == '0);
            neg_q  <= d_nxt[WIDTH-1];
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                      (d_nxt[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign zero = zero_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16).
// Directed cases, reset/backpressure scenarios and a random back-to-back run.
module tb_nibble_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] d;
    logic         b_out;
`ifdef SUB_FLAGS_EN
    logic         zero;
    logic         neg;
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         z;
        logic         n;
        logic         o;
    } exp_t;

    exp_t exp_q[$];

    nibble_serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
`ifdef SUB_FLAGS_EN
        .b_out     (b_out),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
`else
        .b_out     (b_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input logic [W-1:0] ma,
                                   input logic [W-1:0] mb,
                                   input logic mbin);
        exp_t        e;
        logic [W:0]  r;
        longint      s;
        r    = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        s    = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
        e.d  = r[W-1:0];
        e.bo = (longint'(ma) < longint'(mb) + longint'(mbin));
        e.z  = (r[W-1:0] == '0);
        e.n  = r[W-1];
        e.o  = (s > 32767) || (s < -32768);
        return e;
    endfunction

    task automatic start_op(input string tag, input logic [W-1:0] ta,
                            input logic [W-1:0] tb, input logic tbin);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        b_in     = tbin;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] ta,
                             input logic [W-1:0] tb, input logic tbin);
        exp_t e;
        e = model(ta, tb, tbin);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_d"}, 32'(d), 32'(e.d));
        check({tag, "_b_out"}, 32'(b_out), 32'(e.bo));
`ifdef SUB_FLAGS_EN
        check({tag, "_flags"}, {29'd0, zero, neg, ovf}, {29'd0, e.z, e.n, e.o});
`endif
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] ta,
                            input logic [W-1:0] tb, input logic tbin);
        start_op(tag, ta, tb, tbin);
        wait_valid(tag);
        check_res(tag, ta, tb, tbin);
        handshake(tag);
    endtask

    initial begin
        int   accepted;
        int   got;
        int   cyc;
        exp_t e;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        directed("t1", 16'h1234, 16'h0234, 1'b0);
        directed("t2", 16'h0000, 16'h0001, 1'b0);
        directed("t3", 16'h8000, 16'h0000, 1'b1);
        directed("t_id", 16'h5A5A, 16'h0000, 1'b0);

        // Backpressure hold with ignored input pulses
        start_op("bp", 16'hABCD, 16'hABCD, 1'b0);
        wait_valid("bp");
        check_res("bp", 16'hABCD, 16'hABCD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            a        = W'($urandom);
            b        = W'($urandom);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_d", 32'(d), 32'h0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        handshake("bp");

        // Reset in the second RUN cycle discards the operation
        start_op("rst", 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        #1 check("rst_mid_d_partial", 32'(d), 32'h000E);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_d", 32'(d), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        directed("after_rst", 16'h0005, 16'h0003, 1'b0);

        // Random back-to-back stream against the reference queue
        accepted  = 0;
        got       = 0;
        cyc       = 0;
        out_ready = 1'b1;
        while ((accepted < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    got++;
                    check("b2b_result", {15'd0, b_out, d}, {15'd0, e.bo, e.d});
`ifdef SUB_FLAGS_EN
                    check("b2b_flags", {29'd0, zero, neg, ovf},
                          {29'd0, e.z, e.n, e.o});
`endif
                end
            end
            if (accepted < 1000) begin
                in_valid = 1'b1;
                a        = W'($urandom);
                b        = W'($urandom);
                b_in     = 1'($urandom);
                if (in_ready) begin
                    exp_q.push_back(model(a, b, b_in));
                    accepted++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        check("b2b_timeout", 32'(cyc < 20000), 32'd1);
        check("b2b_count", 32'(got), 32'd1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
